bus_xfer_seq: RTL and testbench
===============================

// Module: bus_xfer_seq
// PURPOSE
//  Upstream control stage for the shared 8-bit tri-state register bus (R1,R2,R3,ACC + external pins).
//  Accepts a transfer command (source unit, destination unit) and sequences the per-module Sel/RnW
//  strobes so exactly one driver owns Dbus while the destination captures on a single Clock edge.
//  Replaces hand-driven Sel*/RnW* pins at the bus top level.
// PARAMETERS
//  SETUP_CYCLES  1   cycles source drives bus before dest strobe (bus settle); legal 1..15
// PORTS
//  Clock    in   1  system clock, all state on rising edge
//  Resetn   in   1  asynchronous active-low reset
//  Start    in   1  command valid; accepted on rising edge when Start & Ready
//  Src      in   3  source unit: 0=EXT 1=R1 2=R2 3=R3 4=ACC (5-7 illegal)
//  Dst      in   3  destination unit, same encoding
//  Ready    out  1  command can be accepted this cycle
//  Busy     out  1  transfer in progress (state != IDLE)
//  Done     out  1  one-cycle pulse, transfer completed
//  Err      out  1  one-cycle pulse, command rejected
//  Sel1,RnW1,Sel2,RnW2,Sel3,RnW3,SelA,RnWa  out 1 each  module strobes to bus top level
// BEHAVIOUR
//  Reset: state=IDLE, all Sel*=0, all RnW*=0, Ready=1, Busy=0, Done=0, Err=0, counter=0, queue empty.
//  Reset mid-transfer aborts immediately (async); no Done/Err generated for aborted command.
//  Strobe rule: RnW_x=1 only for selected source module; every other RnW=0 (so EXT drives Dbus
//   whenever no module reads). Sel_x=1 only for source (SETUP/XFER) and dest (XFER).
//  Illegal command: Src>4 | Dst>4 | Src==Dst (incl. EXT->EXT). Accepted, no strobes, Err=1 next cycle, Ready stays 1.
//  FSM (IDLE -> SETUP -> XFER -> DONE -> IDLE):
//   IDLE : Ready=1. Legal Start -> SETUP, load counter=SETUP_CYCLES-1.
//   SETUP: source Sel=1,RnW=1 (EXT source: no Sel). Counter decrements; at 0 -> XFER. Lasts SETUP_CYCLES.
//   XFER : source strobes held, dest Sel=1,RnW=0 for exactly 1 cycle (dest captures at end). EXT dest:
//          no dest Sel, source RnW=1 makes pins driven. -> DONE.
//   DONE : all Sel=0, RnW=0, Done=1 for 1 cycle. -> IDLE, or -> SETUP if a queued command is pending.
//  Latency: accept edge to Done high = SETUP_CYCLES+2 cycles. Min throughput 1 cmd / SETUP_CYCLES+2.
//  Never more than one RnW=1 and never more than two Sel=1 in any cycle; Start while !Ready is ignored.
//  Done and Err never asserted in the same cycle; Err from queued illegal cmd issues in DONE->next slot.
// CONFIGURATION
//  BUS_XFER_CMDQ_EN defined: 2-entry command FIFO in front of FSM. Ready = FIFO not full; commands
//   accepted while Busy; DONE chains straight to SETUP of next legal entry (no IDLE bubble); illegal
//   entries popped with Err pulse, one per cycle. Simultaneous push+pop when full not allowed (Ready=0).
//  Not defined: no FIFO; Ready = (state==IDLE); command latched directly on accept.
// TESTING
//  1 EXT->R2, SETUP_CYCLES=1: Start@t0 -> t1 Sel2=0 all RnW=0; t2 Sel2=1 RnW2=0; t3 Done=1, all strobes 0.
//  2 R1->ACC, SETUP_CYCLES=3: Sel1=RnW1=1 for cycles t1..t4, SelA=1 RnWa=0 at t4 only, Done at t5.
//  3 R3->EXT: RnW3=1 during SETUP+XFER, no other Sel; pins show R3 value (preload 8'hA5) -> DioExt=8'hA5.
//  4 Illegal Src=2,Dst=2 and Src=6: Err pulse next cycle each, no Sel asserted, Busy stays 0.
//  5 Resetn low during SETUP of R1->R2: all strobes 0 same cycle, no Done; post-reset R2 unchanged.
//  6 BUS_XFER_CMDQ_EN: 3 back-to-back Starts; Ready drops after 2 queued, transfers run back-to-back, 3 Done pulses spaced SETUP_CYCLES+2.

Source files
------------

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: sequences the per-module Sel/RnW strobes of the shared 8-bit
// tri-state register bus (EXT pins, R1, R2, R3, ACC) for one source->destination
// transfer. FSM: IDLE -> SETUP (SETUP_CYCLES) -> XFER (1) -> DONE (1) -> IDLE.
// Optional build macro BUS_XFER_CMDQ_EN adds a 2-entry command FIFO so
// transfers chain back-to-back; without it commands are latched directly.
//
// Command handshake: a command {Src, Dst} is transferred on the rising Clock
// edge where Start && Ready; Start while !Ready is ignored and the command
// inputs are don't-care whenever Start is low.
//
// Unit encoding: 0=EXT 1=R1 2=R2 3=R3 4=ACC, 5..7 illegal. SETUP_CYCLES: 1..15.
module bus_xfer_seq #(
  parameter int SETUP_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [2:0] Src,
  input  logic [2:0] Dst,
  output logic       Ready,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic       Sel1,
  output logic       RnW1,
  output logic       Sel2,
  output logic       RnW2,
  output logic       Sel3,
  output logic       RnW3,
  output logic       SelA,
  output logic       RnWa,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETUP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Command presented to the FSM this cycle and whether the FSM consumes it.
  logic [5:0] head_cmd;
  logic       take;

  function automatic logic cmd_legal(input logic [2:0] s, input logic [2:0] d);
    return (s <= 3'd4) && (d <= 3'd4) && (s != d);
  endfunction

`ifdef BUS_XFER_CMDQ_EN
  logic [5:0] fifo_q [2];
  logic [5:0] fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] fill_q, fill_d;
  logic       start_acc, slot_free, push, pop;

  // An empty FIFO is bypassed so a lone command keeps the unqueued latency.
  assign Ready     = (fill_q != 2'd2);
  assign start_acc = Start & Ready;
  assign slot_free = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign head_cmd  = (fill_q != 2'd0) ? fifo_q[rd_ptr_q] : {Src, Dst};
  assign take      = slot_free && ((fill_q != 2'd0) || start_acc);
  assign pop       = take && (fill_q != 2'd0);
  assign push      = start_acc && !(take && (fill_q == 2'd0));

  // FIFO next state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {Src, Dst};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    fill_d = fill_q + {1'b0, push} - {1'b0, pop};
  end

  // FIFO storage and pointers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fill_q    <= 2'd0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end
`else
  assign Ready    = (state_q == ST_IDLE);
  assign head_cmd = {Src, Dst};
  assign take     = Start & Ready;
`endif

  // FSM state, latched command, setup counter and registered Err pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; IDLE and DONE both pick up the next command so a
  // queued one starts SETUP without passing through IDLE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (take) begin
          if (cmd_legal(head_cmd[5:3], head_cmd[2:0])) begin
            state_d = ST_SETUP;
            src_d   = head_cmd[5:3];
            dst_d   = head_cmd[2:0];
            cnt_d   = CNT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_XFER: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes: source drives (Sel+RnW) through SETUP and XFER, destination is
  // selected with RnW=0 only in XFER. Unit 0 (EXT) has no strobes; with no
  // RnW high the external pins own the bus.
  always_comb begin
    logic src_on;
    logic dst_on;
    src_on = (state_q == ST_SETUP) || (state_q == ST_XFER);
    dst_on = (state_q == ST_XFER);
    RnW1   = src_on && (src_q == 3'd1);
    RnW2   = src_on && (src_q == 3'd2);
    RnW3   = src_on && (src_q == 3'd3);
    RnWa   = src_on && (src_q == 3'd4);
    Sel1   = RnW1 || (dst_on && (dst_q == 3'd1));
    Sel2   = RnW2 || (dst_on && (dst_q == 3'd2));
    Sel3   = RnW3 || (dst_on && (dst_q == 3'd3));
    SelA   = RnWa || (dst_on && (dst_q == 3'd4));
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: includes a small model of the register bus
// (R1..ACC plus external pins) driven by the DUT strobes, so every transfer
// is checked for both strobe timing and the data that lands in the target.
`timescale 1ns/1ps
module tb_bus_xfer_seq;

  localparam int SC = 3;
`ifdef BUS_XFER_CMDQ_EN
  localparam logic READY_BUSY = 1'b1;
`else
  localparam logic READY_BUSY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start  = 1'b0;
  logic [2:0] Src    = 3'd0;
  logic [2:0] Dst    = 3'd0;
  logic       Ready, Busy, Done, Err;
  logic       Sel1, RnW1, Sel2, RnW2, Sel3, RnW3, SelA, RnWa;
  logic [1:0] dbg_state;

  always #5 Clock = ~Clock;

  bus_xfer_seq #(.SETUP_CYCLES(SC)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Src(Src), .Dst(Dst),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Err(Err),
    .Sel1(Sel1), .RnW1(RnW1), .Sel2(Sel2), .RnW2(RnW2),
    .Sel3(Sel3), .RnW3(RnW3), .SelA(SelA), .RnWa(RnWa),
    .dbg_state(dbg_state)
  );

  // ---------------- bus model ----------------
  // regs[0] holds what the external pins last saw driven; regs[1..4] = R1,R2,R3,ACC.
  logic [7:0] regs [5];
  logic [7:0] ext_drive = 8'h3C;
  logic       load_en   = 1'b0;
  logic [2:0] load_idx  = 3'd0;
  logic [7:0] load_val  = 8'd0;
  logic [3:0] sel_v, rnw_v;
  logic [7:0] dbus;
  int         cyc = 0;

  assign sel_v = {Sel1, Sel2, Sel3, SelA};
  assign rnw_v = {RnW1, RnW2, RnW3, RnWa};

  always_comb begin
    dbus = ext_drive;
    if (RnW1)      dbus = regs[1];
    else if (RnW2) dbus = regs[2];
    else if (RnW3) dbus = regs[3];
    else if (RnWa) dbus = regs[4];
  end

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (load_en) begin
      regs[load_idx] <= load_val;
    end else begin
      if (Sel1 && !RnW1) regs[1] <= dbus;
      if (Sel2 && !RnW2) regs[2] <= dbus;
      if (Sel3 && !RnW3) regs[3] <= dbus;
      if (SelA && !RnWa) regs[4] <= dbus;
      if (|rnw_v)        regs[0] <= dbus;
    end
  end

  // ---------------- check helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {destination unit, data expected to land there}.
  logic [10:0] exp_q [$];
  int          done_cyc [$];
  int          err_cyc [$];

  always @(posedge Clock) begin
    logic [10:0] e;
    #1;
    if (Done) begin
      done_cyc.push_back(cyc);
      chki("done_expected", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk8("xfer_data", regs[e[10:8]], e[7:0]);
      end
    end
    if (Err) err_cyc.push_back(cyc);
  end

  // Bus-wide invariants, sampled mid-cycle.
  always @(negedge Clock) begin
    if (Resetn) begin
      chk1("max_one_rnw", ($countones(rnw_v) <= 1), 1'b1);
      chk1("max_two_sel", ($countones(sel_v) <= 2), 1'b1);
      chk1("done_err_excl", (Done && Err), 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] oh(input logic [2:0] u);
    case (u)
      3'd1:    oh = 4'b1000;
      3'd2:    oh = 4'b0100;
      3'd3:    oh = 4'b0010;
      3'd4:    oh = 4'b0001;
      default: oh = 4'b0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [7:0] val);
    load_en  = 1'b1;
    load_idx = idx;
    load_val = val;
    tick();
    load_en  = 1'b0;
  endtask

  // Issue one legal transfer and walk it cycle by cycle.
  task automatic run_xfer(input logic [2:0] s, input logic [2:0] d);
    Src = s; Dst = d; Start = 1'b1;
    chk1("ready_idle", Ready, 1'b1);
    exp_q.push_back({d, (s == 3'd0) ? ext_drive : regs[s]});
    tick();
    Start = 1'b0;
    for (int i = 0; i < SC; i++) begin
      chk4("setup_sel", sel_v, oh(s));
      chk4("setup_rnw", rnw_v, oh(s));
      chk1("setup_busy", Busy, 1'b1);
      chk1("setup_ready", Ready, READY_BUSY);
      chk1("setup_done", Done, 1'b0);
      tick();
    end
    chk4("xfer_sel", sel_v, oh(s) | oh(d));
    chk4("xfer_rnw", rnw_v, oh(s));
    chk1("xfer_done", Done, 1'b0);
    tick();
    chk1("done_pulse", Done, 1'b1);
    chk4("done_sel", sel_v, 4'b0000);
    chk4("done_rnw", rnw_v, 4'b0000);
    chk1("done_no_err", Err, 1'b0);
    tick();
    chk1("idle_done", Done, 1'b0);
    chk1("idle_busy", Busy, 1'b0);
    chk1("idle_ready", Ready, 1'b1);
  endtask

  task automatic run_illegal(input logic [2:0] s, input logic [2:0] d);
    Src = s; Dst = d; Start = 1'b1;
    chk1("ill_ready", Ready, 1'b1);
    tick();
    Start = 1'b0;
    chk1("ill_err", Err, 1'b1);
    chk1("ill_busy", Busy, 1'b0);
    chk1("ill_ready_after", Ready, 1'b1);
    chk4("ill_sel", sel_v, 4'b0000);
    chk4("ill_rnw", rnw_v, 4'b0000);
    tick();
    chk1("ill_err_clear", Err, 1'b0);
    chk1("ill_busy2", Busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    // Reset state
    #1;
    chk1("rst_ready", Ready, 1'b1);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_err", Err, 1'b0);
    chk4("rst_sel", sel_v, 4'b0000);
    chk4("rst_rnw", rnw_v, 4'b0000);
    chki("rst_state", int'(dbg_state), 0);
    load_reg(3'd0, 8'h00);
    load_reg(3'd1, 8'h11);
    load_reg(3'd2, 8'h22);
    load_reg(3'd3, 8'hA5);
    load_reg(3'd4, 8'h44);
    @(negedge Clock);
    Resetn = 1'b1;
    tick();

    // EXT -> R2, R1 -> ACC, R3 -> EXT
    run_xfer(3'd0, 3'd2);
    run_xfer(3'd1, 3'd4);
    run_xfer(3'd3, 3'd0);
    chk8("ext_pins_a5", regs[0], 8'hA5);

    // Illegal commands
    run_illegal(3'd2, 3'd2);
    run_illegal(3'd6, 3'd1);
    run_illegal(3'd0, 3'd0);
    run_illegal(3'd1, 3'd5);

    // Asynchronous reset during SETUP of R1 -> R2 (no Done expected)
    load_reg(3'd1, 8'h11);
    load_reg(3'd2, 8'h22);
    Src = 3'd1; Dst = 3'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk4("abort_pre_sel", sel_v, 4'b1000);
    Resetn = 1'b0;
    #1;
    chk4("abort_sel", sel_v, 4'b0000);
    chk4("abort_rnw", rnw_v, 4'b0000);
    chk1("abort_busy", Busy, 1'b0);
    chk1("abort_ready", Ready, 1'b1);
    tick();
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (SC + 3) tick();
    chk8("abort_r2_kept", regs[2], 8'h22);
    chk1("abort_busy_after", Busy, 1'b0);

`ifdef BUS_XFER_CMDQ_EN
    // Three back-to-back commands through the FIFO
    load_reg(3'd1, 8'h5A);
    load_reg(3'd3, 8'hC3);
    ext_drive = 8'h77;
    done_cyc.delete();
    k = cyc;
    Src = 3'd1; Dst = 3'd2; Start = 1'b1;
    chk1("q_ready0", Ready, 1'b1);
    exp_q.push_back({3'd2, 8'h5A});
    tick();
    Src = 3'd3; Dst = 3'd4;
    chk1("q_ready1", Ready, 1'b1);
    exp_q.push_back({3'd4, 8'hC3});
    tick();
    Src = 3'd0; Dst = 3'd1;
    chk1("q_ready2", Ready, 1'b1);
    exp_q.push_back({3'd1, 8'h77});
    tick();
    Start = 1'b0;
    chk1("q_full_ready", Ready, 1'b0);
    repeat (3 * (SC + 2) + 2) tick();
    chki("q_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chki("q_first_latency", done_cyc[0] - k, SC + 2);
      chki("q_spacing01", done_cyc[1] - done_cyc[0], SC + 2);
      chki("q_spacing12", done_cyc[2] - done_cyc[1], SC + 2);
    end

    // Illegal command queued behind a legal one: Err the cycle after Done
    done_cyc.delete();
    err_cyc.delete();
    Src = 3'd4; Dst = 3'd3; Start = 1'b1;
    exp_q.push_back({3'd3, regs[4]});
    tick();
    Src = 3'd5; Dst = 3'd1;
    chk1("qi_ready", Ready, 1'b1);
    tick();
    Start = 1'b0;
    repeat (SC + 4) tick();
    chki("qi_done_count", done_cyc.size(), 1);
    chki("qi_err_count", err_cyc.size(), 1);
    if (done_cyc.size() == 1 && err_cyc.size() == 1) begin
      chki("qi_err_after_done", err_cyc[0] - done_cyc[0], 1);
    end
`else
    // Start while busy is ignored (no Err, Ready low)
    load_reg(3'd1, 8'h6B);
    err_cyc.delete();
    Src = 3'd1; Dst = 3'd3; Start = 1'b1;
    exp_q.push_back({3'd3, 8'h6B});
    tick();
    Src = 3'd2; Dst = 3'd2;
    for (int i = 0; i < SC + 1; i++) begin
      chk1("busy_ready_low", Ready, 1'b0);
      tick();
    end
    Start = 1'b0;
    chk1("busy_done", Done, 1'b1);
    repeat (3) tick();
    chki("busy_no_err", err_cyc.size(), 0);
    chk8("busy_r3", regs[3], 8'h6B);
`endif

    chki("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
